fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch stage that drives the instruction memory's 9-bit combinational read port and registers each 24-bit word into an instruction register for the decode stage. Sits directly upstream of decode and owns the PC, sequential increment, branch/jump redirect with flush, valid/ready back-pressure, and halt detection. Sustains one instruction per cycle when decode is always ready.

## Interface
- RESET_ADDR, 9'd0, PC value loaded on reset
- HALT_OPCODE, 8'hFF, value of instruction bits [23:16] that marks HALT (used only with FETCH_HALT_EN)
- clk  in  1  system clock, all state on rising edge
- rstN  in  1  reset; asynchronous, active-low
- fetchEn  in  1  level; 1 = fetching permitted
- readAddr  out  9  address to instruction memory (combinationally = pc)
- readData  in  24  word from instruction memory, valid same cycle as readAddr
- redirectValid  in  1  one-cycle pulse: load redirectAddr into PC and flush
- redirectAddr  in  9  branch/jump target
- instOut  out  24  registered instruction to decode
- instAddr  out  9  address instOut was fetched from
- instValid  out  1  instOut/instAddr valid
- instReady  in  1  decode accepts instOut this cycle
- halted  out  1  1 while in HALT state
- fetchCount  out  16  number of instructions accepted by decode, saturating

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: no fetches; fetchEn=1 -> RUN next cycle.
- RUN: fetchEn=0 -> IDLE (no fetch this cycle; held output remains valid until accepted).
- Fetch fires in RUN when fetchEn=1, redirectValid=0 and (instValid=0 or instReady=1): instOut<=readData, instAddr<=pc, instValid<=1, pc<=pc+1 mod 512 (511 wraps to 0).
- Accept without fetch (instValid & instReady, no fetch firing): instValid<=0.
- Stall (instValid=1, instReady=0): pc, instOut, instAddr, instValid hold.
- Redirect (any state, priority over fetch and stall): pc<=redirectAddr, instValid<=0 (the held instruction is dropped, not counted); in HALT -> RUN (IDLE stays IDLE). No fetch in the redirect cycle.
- fetchCount increments on instValid & instReady, excluding the redirect cycle (flushed word counts as not accepted); saturates at 16'hFFFF.
- Reset values: pc=RESET_ADDR, readAddr=RESET_ADDR, instOut=0, instAddr=0, instValid=0, halted=0, fetchCount=0, state IDLE. Reset asserted mid-operation clears everything immediately, regardless of handshake.

## Timing
- Fetch latency: word at address A appears on instOut with instValid=1 the cycle after pc=A while fetch fires.
- Throughput: 1 instruction/cycle with instReady held 1.
- Redirect: first instruction from target is valid 2 edges after the redirect edge is sampled (redirect edge, then fetch edge).
- readAddr has zero latency from pc; no combinational path from readData to any output.
- halted asserts the cycle after the HALT word is registered.

## Configuration
- FETCH_HALT_EN defined: a fetch whose readData[23:16]==HALT_OPCODE registers the word normally (instValid=1) but does not advance pc and moves RUN -> HALT; HALT performs no fetches, holds pc at the HALT address, halted=1; only redirect (-> RUN) or reset leaves HALT.
- FETCH_HALT_EN undefined: HALT state absent, HALT_OPCODE ignored, all words fetched sequentially, halted tied 0.

## Test plan
- Reset release, fetchEn=1, instReady=1, memory [0..3]=24'h000001..000004 -> instValid from cycle 2, instOut 000001,000002,000003,000004 with instAddr 0..3; fetchCount=4 after four acceptances.
- instReady=0 for 3 cycles while instOut=000002 -> instOut, instAddr=1, pc=2 held; on instReady=1 next word 000003 follows with no skip or duplicate.
- redirectValid with redirectAddr=9'h100 while stalled on addr 5 -> instValid=0 next cycle, next valid instAddr=9'h100, stalled word not counted in fetchCount.
- pc=511, instReady=1 -> instAddr 511 then 0 (wrap).
- FETCH_HALT_EN, word FF0000 at addr 6 -> instOut=FF0000 valid, halted=1, readAddr stays 6, no further fetches; redirect to 0 -> halted=0, fetch resumes at 0; without macro, addr 7 fetched next, halted=0.
- rstN asserted mid-stream with instValid=1 -> all outputs to reset values asynchronously, state IDLE, fetchCount=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory read port, decode handshake and redirect input.
// The master modport is the fetch unit; the slave modport is memory/decode/branch logic.
interface fetch_unit_if;
    logic [8:0]  readAddr;
    logic [23:0] readData;
    logic        redirectValid;
    logic [8:0]  redirectAddr;
    logic [23:0] instOut;
    logic [8:0]  instAddr;
    logic        instValid;
    logic        instReady;

    modport master (
        output readAddr, instOut, instAddr, instValid,
        input  readData, redirectValid, redirectAddr, instReady
    );

    modport slave (
        input  readAddr, instOut, instAddr, instValid,
        output readData, redirectValid, redirectAddr, instReady
    );
endinterface

// File: rtl/fetch_unit.sv
// PC / fetch stage: drives instruction memory, registers words for decode, handles redirect.
// Optional HALT detection is enabled with the FETCH_HALT_EN macro.
module fetch_unit #(
    parameter logic [8:0] RESET_ADDR  = 9'd0,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               fetchEn,
    fetch_unit_if.master       bus,
    output logic               halted,
    output logic [15:0]        fetchCount
);

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StHalt} stateT;

    stateT       stateQ, stateD;
    logic [8:0]  pcQ;
    logic [23:0] instOutQ;
    logic [8:0]  instAddrQ;
    logic        instValidQ;
    logic [15:0] fetchCountQ;
    logic        fetchFire;
    logic        haltWord;
    logic        accept;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (bus.redirectValid) begin
            if (stateQ == StHalt) stateD = StRun;
        end else begin
            case (stateQ)
                StIdle:  if (fetchEn) stateD = StRun;
                StRun: begin
                    if (!fetchEn)                  stateD = StIdle;
                    else if (fetchFire && haltWord) stateD = StHalt;
                end
                StHalt:  stateD = StHalt;
                default: stateD = StIdle;
            endcase
        end
    end

    // haltWord only steers state/pc; readData never reaches an output combinationally.
    always_comb begin
        fetchFire    = (stateQ == StRun) && fetchEn && !bus.redirectValid &&
                       (!instValidQ || bus.instReady);
        haltWord     = HaltEn && (bus.readData[23:16] == HALT_OPCODE);
        accept       = instValidQ && bus.instReady && !bus.redirectValid;
        halted       = HaltEn && (stateQ == StHalt);
        bus.readAddr = pcQ;
        bus.instOut  = instOutQ;
        bus.instAddr = instAddrQ;
        bus.instValid = instValidQ;
        fetchCount   = fetchCountQ;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pcQ         <= RESET_ADDR;
            instOutQ    <= '0;
            instAddrQ   <= '0;
            instValidQ  <= 1'b0;
            fetchCountQ <= '0;
        end else begin
            if (bus.redirectValid) begin
                pcQ        <= bus.redirectAddr;
                instValidQ <= 1'b0;
            end else if (fetchFire) begin
                instOutQ   <= bus.readData;
                instAddrQ  <= pcQ;
                instValidQ <= 1'b1;
                if (!haltWord) pcQ <= pcQ + 9'd1;
            end else if (instValidQ && bus.instReady) begin
                instValidQ <= 1'b0;
            end

            if (accept && (fetchCountQ != 16'hFFFF)) begin
                fetchCountQ <= fetchCountQ + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {addr,word} pairs are queued as stimulus is
// driven and popped whenever decode accepts an instruction.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rstN;
    logic        fetchEn;
    logic        halted;
    logic [15:0] fetchCount;
    logic [23:0] mem [512];
    logic [32:0] expQ [$];
    int          nChecks = 0;
    int          nPass   = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk        (clk),
        .rstN       (rstN),
        .fetchEn    (fetchEn),
        .bus        (bus),
        .halted     (halted),
        .fetchCount (fetchCount)
    );

    always #5 clk = ~clk;

    assign bus.readData = mem[bus.readAddr];

    // Accept monitor: runs after the per-cycle drives so it sees the values the next edge uses.
    always @(negedge clk) begin
        logic [32:0] e;
        #2;
        if (rstN && bus.instValid && bus.instReady && !bus.redirectValid) begin
            nChecks++;
            if (expQ.size() == 0) begin
                $display("FAIL accept_unexpected: got addr=%h word=%h, required none",
                         bus.instAddr, bus.instOut);
            end else begin
                e = expQ.pop_front();
                if ({bus.instAddr, bus.instOut} !== e)
                    $display("FAIL accept_order: got addr=%h word=%h, required addr=%h word=%h",
                             bus.instAddr, bus.instOut, e[32:24], e[23:0]);
                else nPass++;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] a);
        expQ.push_back({a, mem[a]});
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        fetchEn = 1'b0;
        bus.instReady = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectAddr = '0;
        #2 rstN = 1'b0;
        cyc(); cyc();
        nChecks++; if (bus.readAddr !== 9'd0) $display("FAIL rst_readAddr: got %h required 0", bus.readAddr); else nPass++;
        nChecks++; if (bus.instValid !== 1'b0) $display("FAIL rst_instValid: got %b required 0", bus.instValid); else nPass++;
        nChecks++; if (bus.instOut !== 24'd0) $display("FAIL rst_instOut: got %h required 0", bus.instOut); else nPass++;
        nChecks++; if (bus.instAddr !== 9'd0) $display("FAIL rst_instAddr: got %h required 0", bus.instAddr); else nPass++;
        nChecks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b required 0", halted); else nPass++;
        nChecks++; if (fetchCount !== 16'd0) $display("FAIL rst_fetchCount: got %h required 0", fetchCount); else nPass++;
    endtask

    task automatic test_sequential();
        cyc();
        rstN = 1'b1; fetchEn = 1'b1; bus.instReady = 1'b1;
        for (int i = 0; i < 4; i++) push(9'(i));
        cyc();
        nChecks++; if (bus.instValid !== 1'b0) $display("FAIL seq_idle_gap: got %b required 0", bus.instValid); else nPass++;
        cyc(); cyc(); cyc(); cyc();
        fetchEn = 1'b0;
        cyc();
        nChecks++; if (fetchCount !== 16'd4) $display("FAIL seq_count: got %0d required 4", fetchCount); else nPass++;
        nChecks++; if (bus.readAddr !== 9'd4) $display("FAIL seq_pc: got %h required 4", bus.readAddr); else nPass++;
    endtask

    task automatic test_stall();
        cyc();
        bus.redirectValid = 1'b1; bus.redirectAddr = 9'd1; bus.instReady = 1'b0;
        cyc();
        bus.redirectValid = 1'b0; fetchEn = 1'b1;
        nChecks++; if (bus.readAddr !== 9'd1) $display("FAIL stall_idle_redirect: got %h required 1", bus.readAddr); else nPass++;
        push(9'd1); push(9'd2);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            nChecks++;
            if ({bus.instValid, bus.instOut, bus.instAddr, bus.readAddr} !== {1'b1, 24'h000002, 9'd1, 9'd2})
                $display("FAIL stall_hold: got v=%b out=%h addr=%h pc=%h required v=1 out=000002 addr=1 pc=2",
                         bus.instValid, bus.instOut, bus.instAddr, bus.readAddr);
            else nPass++;
        end
        bus.instReady = 1'b1;
        cyc();
        fetchEn = 1'b0;
        cyc();
        nChecks++; if (bus.instValid !== 1'b0) $display("FAIL stall_drain: got %b required 0", bus.instValid); else nPass++;
        nChecks++; if (fetchCount !== 16'd6) $display("FAIL stall_count: got %0d required 6", fetchCount); else nPass++;
    endtask

    task automatic test_redirect();
        cyc();
        bus.redirectValid = 1'b1; bus.redirectAddr = 9'd5;
        cyc();
        bus.redirectValid = 1'b0; fetchEn = 1'b1; bus.instReady = 1'b0;
        cyc(); cyc();
        nChecks++; if ({bus.instValid, bus.instAddr} !== {1'b1, 9'd5}) $display("FAIL redir_stalled: got v=%b addr=%h required v=1 addr=005", bus.instValid, bus.instAddr); else nPass++;
        bus.redirectValid = 1'b1; bus.redirectAddr = 9'h100; bus.instReady = 1'b1;
        cyc();
        bus.redirectValid = 1'b0;
        nChecks++; if (bus.instValid !== 1'b0) $display("FAIL redir_flush: got %b required 0", bus.instValid); else nPass++;
        nChecks++; if (fetchCount !== 16'd6) $display("FAIL redir_nocount: got %0d required 6", fetchCount); else nPass++;
        nChecks++; if (bus.readAddr !== 9'h100) $display("FAIL redir_pc: got %h required 100", bus.readAddr); else nPass++;
        push(9'h100);
        cyc();
        nChecks++; if (bus.instValid !== 1'b1) $display("FAIL redir_latency: got %b required 1", bus.instValid); else nPass++;
        fetchEn = 1'b0;
        cyc();
        nChecks++; if (fetchCount !== 16'd7) $display("FAIL redir_count: got %0d required 7", fetchCount); else nPass++;
    endtask

    task automatic test_wrap();
        cyc();
        bus.redirectValid = 1'b1; bus.redirectAddr = 9'd510;
        cyc();
        bus.redirectValid = 1'b0; fetchEn = 1'b1;
        push(9'd510); push(9'd511); push(9'd0);
        cyc(); cyc(); cyc();
        nChecks++; if (bus.readAddr !== 9'd0) $display("FAIL wrap_pc: got %h required 0", bus.readAddr); else nPass++;
        cyc();
        fetchEn = 1'b0;
        cyc();
        nChecks++; if (fetchCount !== 16'd10) $display("FAIL wrap_count: got %0d required 10", fetchCount); else nPass++;
    endtask

    task automatic test_halt();
        cyc();
        bus.redirectValid = 1'b1; bus.redirectAddr = 9'd6;
        cyc();
        bus.redirectValid = 1'b0; fetchEn = 1'b1;
        push(9'd6);
`ifndef FETCH_HALT_EN
        push(9'd7);
`endif
        cyc(); cyc();
        nChecks++; if ({bus.instValid, bus.instOut} !== {1'b1, 24'hFF0000}) $display("FAIL halt_word: got v=%b out=%h required v=1 out=ff0000", bus.instValid, bus.instOut); else nPass++;
`ifdef FETCH_HALT_EN
        nChecks++; if ({halted, bus.readAddr} !== {1'b1, 9'd6}) $display("FAIL halt_enter: got halted=%b pc=%h required halted=1 pc=006", halted, bus.readAddr); else nPass++;
        for (int i = 0; i < 2; i++) begin
            cyc();
            nChecks++;
            if ({bus.instValid, halted, bus.readAddr} !== {1'b0, 1'b1, 9'd6})
                $display("FAIL halt_hold: got v=%b halted=%b pc=%h required v=0 halted=1 pc=006", bus.instValid, halted, bus.readAddr);
            else nPass++;
        end
        bus.redirectValid = 1'b1; bus.redirectAddr = 9'd0;
        cyc();
        bus.redirectValid = 1'b0;
        nChecks++; if ({halted, bus.readAddr} !== {1'b0, 9'd0}) $display("FAIL halt_exit: got halted=%b pc=%h required halted=0 pc=000", halted, bus.readAddr); else nPass++;
        push(9'd0);
        cyc();
        nChecks++; if (bus.instValid !== 1'b1) $display("FAIL halt_resume: got %b required 1", bus.instValid); else nPass++;
        fetchEn = 1'b0;
        cyc();
`else
        nChecks++; if ({halted, bus.readAddr} !== {1'b0, 9'd7}) $display("FAIL nohalt_pc: got halted=%b pc=%h required halted=0 pc=007", halted, bus.readAddr); else nPass++;
        cyc();
        nChecks++; if ({bus.instValid, bus.instAddr} !== {1'b1, 9'd7}) $display("FAIL nohalt_next: got v=%b addr=%h required v=1 addr=007", bus.instValid, bus.instAddr); else nPass++;
        fetchEn = 1'b0;
        cyc();
        nChecks++; if (halted !== 1'b0) $display("FAIL nohalt_halted: got %b required 0", halted); else nPass++;
`endif
        nChecks++; if (fetchCount !== 16'd12) $display("FAIL halt_count: got %0d required 12", fetchCount); else nPass++;
    endtask

    task automatic test_reset_mid();
        cyc();
        fetchEn = 1'b1; bus.instReady = 1'b0;
        cyc(); cyc();
        nChecks++; if (bus.instValid !== 1'b1) $display("FAIL rmid_pre: got %b required 1", bus.instValid); else nPass++;
        rstN = 1'b0;
        #1;
        nChecks++;
        if ({bus.instValid, bus.instOut, bus.instAddr, bus.readAddr, halted, fetchCount} !== {1'b0, 24'd0, 9'd0, 9'd0, 1'b0, 16'd0})
            $display("FAIL rmid_async: got v=%b out=%h addr=%h pc=%h halted=%b cnt=%0d required all zero",
                     bus.instValid, bus.instOut, bus.instAddr, bus.readAddr, halted, fetchCount);
        else nPass++;
        cyc();
        rstN = 1'b1; bus.instReady = 1'b1;
        push(9'd0);
        cyc();
        nChecks++; if (bus.instValid !== 1'b0) $display("FAIL rmid_idle: got %b required 0", bus.instValid); else nPass++;
        cyc();
        nChecks++; if ({bus.instValid, bus.instAddr} !== {1'b1, 9'd0}) $display("FAIL rmid_restart: got v=%b addr=%h required v=1 addr=000", bus.instValid, bus.instAddr); else nPass++;
        fetchEn = 1'b0;
        cyc();
        nChecks++; if (fetchCount !== 16'd1) $display("FAIL rmid_count: got %0d required 1", fetchCount); else nPass++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 24'(i + 1);
        mem[6] = 24'hFF0000;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        cyc();
        nChecks++; if (expQ.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", expQ.size()); else nPass++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
